// File: rtl/ram256_arbiter_pkg.sv
// Shared types and helpers for the 256x32 block-RAM controller/arbiter.
package ram256_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        PORT_A,
        PORT_B
    } port_e;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    // Expand byte enables into a per-bit mask; a 1 marks a bit that will be written.
    function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ram256_arbiter_if.sv
// Request/response bundle between the CPU front-end/LSU and the RAM arbiter.
interface ram256_arbiter_if;
    import ram256_pkg::*;

    // Port A: read-only instruction fetch
    logic              a_req_valid;
    logic              a_req_ready;
    logic [ADDR_W-1:0] a_addr;
    logic              a_rsp_valid;
    logic [DATA_W-1:0] a_rdata;

    // Port B: load/store with byte enables
    logic              b_req_valid;
    logic              b_req_ready;
    logic              b_we;
    logic [BE_W-1:0]   b_be;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_rsp_valid;
    logic [DATA_W-1:0] b_rdata;

    // Requester side (CPU front-end and LSU)
    modport master (
        output a_req_valid, a_addr,
        input  a_req_ready, a_rsp_valid, a_rdata,
        output b_req_valid, b_we, b_be, b_addr, b_wdata,
        input  b_req_ready, b_rsp_valid, b_rdata
    );

    // Arbiter side
    modport slave (
        input  a_req_valid, a_addr,
        output a_req_ready, a_rsp_valid, a_rdata,
        input  b_req_valid, b_we, b_be, b_addr, b_wdata,
        output b_req_ready, b_rsp_valid, b_rdata
    );

endinterface

// File: rtl/ram256_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter: one-hot grant, at most one grant per cycle.
module rr_arbiter2
    import ram256_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] valid,   // bit 0 = port A, bit 1 = port B
    output logic [1:0] grant
);

    port_e last_grant_reg;

    // Lone requester wins; on contention the port not served last time wins.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = (last_grant_reg == PORT_B) ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    // Remember who was served; starts at B so that A wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg <= PORT_B;
        end else if (grant[0]) begin
            last_grant_reg <= PORT_A;
        end else if (grant[1]) begin
            last_grant_reg <= PORT_B;
        end
    end

endmodule

// File: rtl/ram256_arbiter.sv
// Controller and two-port arbiter for a 256x32 block RAM built from two 256x16 halves.
// Optionally zero-fills the RAM after reset, then serves one request per cycle.
module ram256_arbiter
    import ram256_pkg::*;
#(
    parameter bit INIT_EN = 1'b1,
    parameter int DEPTH   = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    ram256_arbiter_if.slave   bus,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_mask,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              init_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              init_done_reg;
    logic              rsp_valid_reg;
    port_e             rsp_port_reg;
    logic              rsp_write_reg;   // response is a write acknowledge
    logic [1:0]        grant;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (state_reg == RUN),
        .valid   ({bus.b_req_valid, bus.a_req_valid}),
        .grant   (grant)
    );

    assign bus.a_req_ready = grant[0];
    assign bus.b_req_ready = grant[1];

    // Sequencer: zero-fill walk, then track the single outstanding response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= INIT_EN ? INIT : RUN;
            cnt_reg       <= '0;
            init_done_reg <= ~INIT_EN;
            rsp_valid_reg <= 1'b0;
            rsp_port_reg  <= PORT_A;
            rsp_write_reg <= 1'b0;
        end else begin
            rsp_valid_reg <= |grant;
            rsp_port_reg  <= grant[1] ? PORT_B : PORT_A;
            rsp_write_reg <= grant[1] & bus.b_we;
            case (state_reg)
                INIT: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == LAST_ADDR) begin
                        state_reg     <= RUN;
                        init_done_reg <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // RAM pins follow the grant in the same cycle; the init write is held off while
    // reset is asserted so the RAM sees no write enable during reset.
    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = '0;
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        ram_mask  = '1;
        if (state_reg == INIT) begin
            ram_we    = reset_n;
            ram_waddr = cnt_reg;
            ram_mask  = '0;
        end else if (grant[0]) begin
            ram_re    = 1'b1;
            ram_raddr = bus.a_addr;
        end else if (grant[1]) begin
            if (bus.b_we) begin
                ram_we    = 1'b1;
                ram_waddr = bus.b_addr;
                ram_wdata = bus.b_wdata;
                ram_mask  = ~be_to_mask(bus.b_be);
            end else begin
                ram_re    = 1'b1;
                ram_raddr = bus.b_addr;
            end
        end
    end

    // Responses: RAM read data arrives the cycle after the grant; write acks return zero.
    always_comb begin
        bus.a_rsp_valid = rsp_valid_reg && (rsp_port_reg == PORT_A);
        bus.b_rsp_valid = rsp_valid_reg && (rsp_port_reg == PORT_B);
        bus.a_rdata     = ram_rdata;
        bus.b_rdata     = rsp_write_reg ? '0 : ram_rdata;
    end

    assign init_done = init_done_reg;

endmodule

// File: tb/tb_ram256_arbiter.sv
// Directed self-checking bench for ram256_arbiter with a behavioural RAM model.
module tb_ram256_arbiter;
    import ram256_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ram_re, ram_we, init_done;
    logic [7:0]  ram_raddr, ram_waddr;
    logic [31:0] ram_wdata, ram_mask;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] mem [0:255];
    bit          seeded = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ram256_arbiter_if bus();

    ram256_arbiter #(.INIT_EN(1'b1), .DEPTH(256)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_mask  (ram_mask),
        .ram_rdata (ram_rdata),
        .init_done (init_done)
    );

    // RAM model: posedge read and write, mask bit 1 = bit kept. Seeded with a
    // non-zero pattern so that the zero-fill is observable.
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5A5A5;
            seeded <= 1'b1;
        end else begin
            if (ram_we) mem[ram_waddr] <= (mem[ram_waddr] & ram_mask) | (ram_wdata & ~ram_mask);
            if (ram_re) ram_rdata <= mem[ram_raddr];
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.a_req_valid = 1'b0; bus.a_addr = 8'h00;
        bus.b_req_valid = 1'b0; bus.b_we = 1'b0; bus.b_be = 4'h0;
        bus.b_addr = 8'h00; bus.b_wdata = 32'h0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) next_cycle();
        $display("txn: reset held");
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        n_checks++; if (bus.a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_rsp: got %b want 0", bus.a_rsp_valid); end
        n_checks++; if (bus.b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_rsp: got %b want 0", bus.b_rsp_valid); end
        n_checks++; if (ram_re !== 1'b0) begin n_fail++; $display("FAIL reset_ram_re: got %b want 0", ram_re); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
    endtask

    task automatic test_init();
        bus.a_req_valid = 1'b1; bus.a_addr = 8'h33;
        bus.b_req_valid = 1'b1; bus.b_we = 1'b1; bus.b_be = 4'hF; bus.b_addr = 8'h44; bus.b_wdata = 32'h12345678;
        reset_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            #1;
            n_checks++;
            if (ram_we !== 1'b1 || ram_waddr !== 8'(i) || ram_wdata !== 32'h0 || ram_mask !== 32'h0) begin
                n_fail++;
                $display("FAIL init_write[%0d]: got we=%b waddr=%h wdata=%h mask=%h want we=1 waddr=%h wdata=0 mask=0",
                         i, ram_we, ram_waddr, ram_wdata, ram_mask, 8'(i));
            end
            n_checks++;
            if (bus.a_req_ready !== 1'b0 || bus.b_req_ready !== 1'b0 || init_done !== 1'b0 || ram_re !== 1'b0) begin
                n_fail++;
                $display("FAIL init_busy[%0d]: got a_rdy=%b b_rdy=%b init_done=%b re=%b want all 0",
                         i, bus.a_req_ready, bus.b_req_ready, init_done, ram_re);
            end
            if (i == 255) idle_inputs();
            next_cycle();
        end
        $display("txn: init walk complete");
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done_rise: got %b want 1", init_done); end
        n_checks++; if (mem[0] !== 32'h0) begin n_fail++; $display("FAIL init_mem0: got %h want 0", mem[0]); end
        n_checks++; if (mem[128] !== 32'h0) begin n_fail++; $display("FAIL init_mem128: got %h want 0", mem[128]); end
        n_checks++; if (mem[255] !== 32'h0) begin n_fail++; $display("FAIL init_mem255: got %h want 0", mem[255]); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL run_idle_we: got %b want 0", ram_we); end
    endtask

    task automatic test_b_write_read();
        bus.b_req_valid = 1'b1; bus.b_we = 1'b1; bus.b_be = 4'hF; bus.b_addr = 8'h10; bus.b_wdata = 32'hDEADBEEF;
        #1;
        $display("txn: B write addr=10 data=deadbeef be=f");
        n_checks++; if (bus.b_req_ready !== 1'b1 || bus.a_req_ready !== 1'b0) begin n_fail++; $display("FAIL bw_ready: got a=%b b=%b want a=0 b=1", bus.a_req_ready, bus.b_req_ready); end
        n_checks++; if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_waddr !== 8'h10) begin n_fail++; $display("FAIL bw_ram_ctl: got we=%b re=%b waddr=%h want we=1 re=0 waddr=10", ram_we, ram_re, ram_waddr); end
        n_checks++; if (ram_wdata !== 32'hDEADBEEF || ram_mask !== 32'h0) begin n_fail++; $display("FAIL bw_ram_data: got wdata=%h mask=%h want deadbeef/00000000", ram_wdata, ram_mask); end
        next_cycle();
        n_checks++; if (bus.b_rsp_valid !== 1'b1 || bus.b_rdata !== 32'h0) begin n_fail++; $display("FAIL bw_ack: got valid=%b rdata=%h want valid=1 rdata=0", bus.b_rsp_valid, bus.b_rdata); end
        bus.b_we = 1'b0;
        #1;
        $display("txn: B read addr=10");
        n_checks++; if (bus.b_req_ready !== 1'b1 || ram_re !== 1'b1 || ram_raddr !== 8'h10 || ram_we !== 1'b0) begin n_fail++; $display("FAIL br_ram_ctl: got rdy=%b re=%b raddr=%h we=%b want 1/1/10/0", bus.b_req_ready, ram_re, ram_raddr, ram_we); end
        next_cycle();
        idle_inputs();
        n_checks++; if (bus.b_rsp_valid !== 1'b1 || bus.b_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL br_rsp: got valid=%b rdata=%h want 1/deadbeef", bus.b_rsp_valid, bus.b_rdata); end
        n_checks++; if (bus.a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL br_no_a_rsp: got %b want 0", bus.a_rsp_valid); end
        next_cycle();
        n_checks++; if (bus.b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL br_rsp_one_cycle: got %b want 0", bus.b_rsp_valid); end
    endtask

    task automatic test_byte_enables();
        bus.b_req_valid = 1'b1; bus.b_we = 1'b1; bus.b_be = 4'b0101; bus.b_addr = 8'h10; bus.b_wdata = 32'h11223344;
        #1;
        $display("txn: B write addr=10 data=11223344 be=5");
        n_checks++; if (ram_mask !== 32'hFF00FF00) begin n_fail++; $display("FAIL be0101_mask: got %h want ff00ff00", ram_mask); end
        next_cycle();
        bus.b_be = 4'b0000; bus.b_wdata = 32'hFFFFFFFF;
        #1;
        $display("txn: B write addr=10 data=ffffffff be=0");
        n_checks++; if (bus.b_req_ready !== 1'b1 || ram_mask !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL be0000_mask: got rdy=%b mask=%h want 1/ffffffff", bus.b_req_ready, ram_mask); end
        next_cycle();
        n_checks++; if (bus.b_rsp_valid !== 1'b1 || bus.b_rdata !== 32'h0) begin n_fail++; $display("FAIL be0000_ack: got valid=%b rdata=%h want 1/0", bus.b_rsp_valid, bus.b_rdata); end
        bus.b_we = 1'b0;
        $display("txn: B read addr=10");
        next_cycle();
        idle_inputs();
        n_checks++; if (bus.b_rsp_valid !== 1'b1 || bus.b_rdata !== 32'hDE22BE44) begin n_fail++; $display("FAIL be_merge_read: got valid=%b rdata=%h want 1/de22be44", bus.b_rsp_valid, bus.b_rdata); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic exp_a;
        bus.a_req_valid = 1'b1; bus.a_addr = 8'h10;
        bus.b_req_valid = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h10;
        for (int k = 0; k < 6; k++) begin
            exp_a = (k % 2 == 0);
            #1;
            $display("txn: contention cycle %0d, expect grant %s", k, exp_a ? "A" : "B");
            n_checks++; if (bus.a_req_ready !== exp_a || bus.b_req_ready !== !exp_a) begin n_fail++; $display("FAIL rr_grant[%0d]: got a=%b b=%b want a=%b b=%b", k, bus.a_req_ready, bus.b_req_ready, exp_a, !exp_a); end
            next_cycle();
            if (k == 5) idle_inputs();
            n_checks++; if (bus.a_rsp_valid !== exp_a || bus.b_rsp_valid !== !exp_a) begin n_fail++; $display("FAIL rr_rsp[%0d]: got a=%b b=%b want a=%b b=%b", k, bus.a_rsp_valid, bus.b_rsp_valid, exp_a, !exp_a); end
            n_checks++;
            if ((exp_a ? bus.a_rdata : bus.b_rdata) !== 32'hDE22BE44) begin
                n_fail++;
                $display("FAIL rr_rdata[%0d]: got %h want de22be44", k, exp_a ? bus.a_rdata : bus.b_rdata);
            end
        end
        next_cycle();
        n_checks++; if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got a=%b b=%b want 0/0", bus.a_rsp_valid, bus.b_rsp_valid); end
    endtask

    task automatic test_back_to_back();
        bus.b_req_valid = 1'b1; bus.b_we = 1'b1; bus.b_be = 4'hF; bus.b_addr = 8'h20; bus.b_wdata = 32'h5;
        $display("txn: B write addr=20 data=5");
        next_cycle();
        bus.b_req_valid = 1'b0; bus.b_we = 1'b0;
        bus.a_req_valid = 1'b1; bus.a_addr = 8'h20;
        #1;
        $display("txn: A read addr=20");
        n_checks++; if (bus.a_req_ready !== 1'b1 || ram_raddr !== 8'h20) begin n_fail++; $display("FAIL b2b_a_grant: got rdy=%b raddr=%h want 1/20", bus.a_req_ready, ram_raddr); end
        next_cycle();
        idle_inputs();
        n_checks++; if (bus.a_rsp_valid !== 1'b1 || bus.a_rdata !== 32'h5) begin n_fail++; $display("FAIL b2b_a_rsp: got valid=%b rdata=%h want 1/00000005", bus.a_rsp_valid, bus.a_rdata); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bus.a_req_valid = 1'b1; bus.a_addr = 8'h20;
        #1;
        $display("txn: A read addr=20 then reset");
        n_checks++; if (bus.a_req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_grant: got %b want 1", bus.a_req_ready); end
        #2;
        reset_n = 1'b0;
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            n_checks++; if (bus.a_rsp_valid !== 1'b0 || bus.b_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drop[%0d]: got a=%b b=%b want 0/0", k, bus.a_rsp_valid, bus.b_rsp_valid); end
        end
        reset_n = 1'b1;
        bus.a_req_valid = 1'b1;
        #1;
        n_checks++; if (ram_we !== 1'b1 || ram_waddr !== 8'h00 || init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_restart: got we=%b waddr=%h init_done=%b want 1/00/0", ram_we, ram_waddr, init_done); end
        n_checks++; if (bus.a_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_init_ready: got %b want 0", bus.a_req_ready); end
        next_cycle();
        #1;
        n_checks++; if (ram_waddr !== 8'h01 || bus.a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_init_step: got waddr=%h a_rsp=%b want 01/0", ram_waddr, bus.a_rsp_valid); end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_init();
        test_b_write_read();
        test_byte_enables();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
